// File: rtl/uart_tx_pkg.sv
// Shared constants for the UART transmitter: FSM encodings and default sizing.
package uart_tx_pkg;

  localparam int unsigned DefClksPerBit = 87;
  localparam int unsigned DefFifoDepth  = 4;

  // Kept as plain constants so older code that compares raw state bits still works.
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

endpackage

// File: rtl/uart_tx_if.sv
// CPU-side write port of the UART transmitter.
interface uart_tx_if;

  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       busy;
  logic       overflow;

  modport master (
    output wr_en,
    output wr_data,
    input  full,
    input  busy,
    input  overflow
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    output full,
    output busy,
    output overflow
  );

endinterface

// File: rtl/tx_fifo.sv
// Transmit byte FIFO; pushes while full are ignored, full is a registered flag.
module tx_fifo
  import uart_tx_pkg::*;
#(
  parameter int unsigned DEPTH = DefFifoDepth
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q, count_d;
  logic            full_q;
  logic            do_push, do_pop;

  assign do_push = push & ~full_q;
  assign do_pop  = pop & (count_q != '0);

  // Occupancy update; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
      full_q  <= (count_d == (PtrW + 1)'(DEPTH));
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = full_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small write FIFO; frames run back to back while data is queued.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DefClksPerBit,
  parameter int unsigned FIFO_DEPTH   = DefFifoDepth
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_tx_if.slave bus,
  output logic     tx
);

  localparam int unsigned  CntW      = $clog2(CLKS_PER_BIT);
  localparam int unsigned  PtrW      = $clog2(FIFO_DEPTH);
  localparam logic [CntW-1:0] CntReload = CntW'(CLKS_PER_BIT - 1);

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            overflow_q;

  logic            fifo_pop;
  logic [7:0]      fifo_dout;
  logic [PtrW:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic            bit_done;

  tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.wr_en),
    .pop   (fifo_pop),
    .din   (bus.wr_data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full)
  );

  assign fifo_empty = (fifo_count == '0);
  assign bit_done   = (cnt_q == '0);

  // Next-state: baud down-counter, bit index and FIFO pop at frame boundaries.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          cnt_d    = CntReload;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (bit_done) begin
          cnt_d     = CntReload;
          bit_idx_d = 3'd0;
          state_d   = StData;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StData: begin
        if (bit_done) begin
          cnt_d     = CntReload;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = StStop;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StStop: begin
        if (bit_done) begin
          if (!fifo_empty) begin
            // Chain straight into the next start bit with no idle cycle.
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            cnt_d    = CntReload;
            state_d  = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level for the current state; registered below so tx never glitches.
  always_comb begin
    case (state_q)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_q[bit_idx_q];
      default: tx_d = 1'b1;
    endcase
  end

  // State registers; reset aborts any frame and forces the line idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_q | (bus.wr_en & fifo_full);
    end
  end

  assign tx           = tx_q;
  assign bus.full     = fifo_full;
  assign bus.overflow = overflow_q;
  assign bus.busy     = !fifo_empty || (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_uart_tx;

  logic clk;
  logic rst_n;
  logic tx;

  uart_tx_if bus ();

  uart_tx #(
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .tx    (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_frames = 0;
  logic [7:0]  exp_q[$];
  longint      frame_starts[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive_write(input logic [7:0] b, input bit accept);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    if (accept) exp_q.push_back(b);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int k = 0;
    while (n_frames < target && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("frames_seen", 32'(n_frames), 32'(target));
  endtask

  // Receiver: samples every negedge of a frame, checks bit widths and framing.
  initial begin : monitor
    logic [9:0] bits;
    logic       stable;
    logic       aborted;
    longint     t_start;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        t_start = $time;
        stable  = 1'b1;
        aborted = 1'b0;
        bits    = '0;
        for (int k = 0; k < 10; k++) begin
          for (int s = 0; s < 4; s++) begin
            if (!(k == 0 && s == 0)) @(negedge clk);
            if (rst_n !== 1'b1) aborted = 1'b1;
            if (s == 0) bits[k] = tx;
            else if (tx !== bits[k]) stable = 1'b0;
          end
        end
        if (!aborted) begin
          frame_starts.push_back(t_start);
          check("bit_width", 32'(stable), 32'(1));
          check("start_bit", 32'(bits[0]), 32'(0));
          check("stop_bit", 32'(bits[9]), 32'(1));
          if (exp_q.size() == 0) check("unexpected_frame", 32'(bits[8:1]), 32'h100);
          else check("frame_data", 32'(bits[8:1]), 32'(exp_q.pop_front()));
          n_frames++;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1);
  end

  initial begin : stim
    longint     tw;
    int         base;
    int         lows;
    logic [7:0] burst [6];
    burst = '{8'h81, 8'h42, 8'h24, 8'h18, 8'hE7, 8'h99};

    rst_n       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'(1));
    check("rst_full", 32'(bus.full), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_overflow", 32'(bus.overflow), 32'(0));
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single byte from idle: start bit two edges after the write, busy spans 40 bit-clocks.
    base = n_frames;
    @(negedge clk);
    tw = $time;
    drive_write(8'h55, 1'b1);
    @(negedge clk);
    bus.wr_en = 1'b0;
    repeat (40) @(negedge clk);
    check("t1_busy_late", 32'(bus.busy), 32'(1));
    @(negedge clk);
    check("t1_busy_fall", 32'(bus.busy), 32'(0));
    wait_frames(base + 1, 20);
    if (frame_starts.size() > base)
      check("t1_start_latency", 32'(frame_starts[base] - tw), 32'(30));

    // Two bytes back to back: no idle gap, 80 cycles total.
    repeat (5) @(negedge clk);
    base = n_frames;
    @(negedge clk);
    tw = $time;
    drive_write(8'hA5, 1'b1);
    @(negedge clk);
    drive_write(8'h3C, 1'b1);
    @(negedge clk);
    bus.wr_en = 1'b0;
    repeat (79) @(negedge clk);
    check("t2_busy_late", 32'(bus.busy), 32'(1));
    @(negedge clk);
    check("t2_busy_fall", 32'(bus.busy), 32'(0));
    wait_frames(base + 2, 20);
    if (frame_starts.size() > base + 1)
      check("t2_gap", 32'(frame_starts[base+1] - frame_starts[base]), 32'(400));

    // Six bytes: five accepted, sixth dropped and flagged.
    repeat (5) @(negedge clk);
    base = n_frames;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 4) check("t3_full_before_5th", 32'(bus.full), 32'(0));
      if (i == 5) check("t3_full_after_5th", 32'(bus.full), 32'(1));
      drive_write(burst[i], i < 5);
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
    check("t3_overflow", 32'(bus.overflow), 32'(1));
    wait_frames(base + 5, 260);
    for (int i = 0; i < 4; i++)
      if (frame_starts.size() > base + i + 1)
        check("t3_gap", 32'(frame_starts[base+i+1] - frame_starts[base+i]), 32'(400));
    repeat (10) @(negedge clk);
    check("t3_no_extra_frame", 32'(n_frames), 32'(base + 5));
    check("t3_scoreboard_empty", 32'(exp_q.size()), 32'(0));
    check("t3_idle_busy", 32'(bus.busy), 32'(0));

    // Write while full on the STOP-end pop edge: dropped, occupancy drops to 3.
    rst_n = 1'b0;
    #1;
    check("t4_rst_overflow", 32'(bus.overflow), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = n_frames;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      drive_write(8'h61 + 8'(i), 1'b1);
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
    repeat (35) @(negedge clk);
    @(negedge clk);
    check("t4_full_at_pop", 32'(bus.full), 32'(1));
    drive_write(8'hCC, 1'b0);
    @(negedge clk);
    bus.wr_en = 1'b0;
    check("t4_count_after_pop", 32'(dut.fifo_count), 32'(3));
    check("t4_full_after_pop", 32'(bus.full), 32'(0));
    check("t4_overflow", 32'(bus.overflow), 32'(1));
    wait_frames(base + 5, 220);

    // Reset during data bit 3 of 0xF0 with a second byte queued.
    repeat (10) @(negedge clk);
    base = n_frames;
    @(negedge clk);
    drive_write(8'hF0, 1'b1);
    @(negedge clk);
    drive_write(8'h77, 1'b1);
    @(negedge clk);
    bus.wr_en = 1'b0;
    repeat (18) @(negedge clk);
    check("t5_bit3_low", 32'(tx), 32'(0));
    rst_n = 1'b0;
    #1;
    check("t5_rst_tx", 32'(tx), 32'(1));
    check("t5_rst_busy", 32'(bus.busy), 32'(0));
    check("t5_rst_overflow", 32'(bus.overflow), 32'(0));
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || bus.busy !== 1'b0) lows++;
    end
    check("t5_stays_idle", 32'(lows), 32'(0));
    check("t5_no_frame", 32'(n_frames), 32'(base));
    @(negedge clk);
    drive_write(8'h00, 1'b1);
    @(negedge clk);
    bus.wr_en = 1'b0;
    wait_frames(base + 1, 60);
    repeat (5) @(negedge clk);
    check("t5_scoreboard_empty", 32'(exp_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
